// File: rtl/adj_key_ctrl.sv
// adj_key_ctrl: synchronises and debounces the active-low up/down push-buttons,
// decodes a single direction, and issues level-held inc/dec requests with
// frame-paced auto-repeat. Each request stays up until a frame_en cycle
// consumes it, so the brightness stage takes exactly one step per request.
module adj_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6,
    parameter int FR_W            = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up_n,
    input  logic key_dn_n,
    input  logic frame_en,
    output logic inc,
    output logic dec,
    output logic busy
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0]  FR_DELAY  = FR_W'(REPEAT_DELAY);
    localparam logic [FR_W-1:0]  FR_RATE   = FR_W'(REPEAT_RATE);

    // Key index 0 is "up", index 1 is "down".
    logic [1:0] raw_n;
    logic [1:0] acc;

    assign raw_n = {key_dn_n, key_up_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic             s1_q;
            logic             s2_q;
            logic             acc_q;
            logic             acc_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             pressed;

            assign pressed = ~s2_q;

            // Two-flop synchroniser; reset value is "released".
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_q <= 1'b1;
                    s2_q <= 1'b1;
                end else begin
                    s1_q <= raw_n[gi];
                    s2_q <= s1_q;
                end
            end

            // Debounce next state: count cycles the synced level disagrees
            // with the accepted level; flip after DEBOUNCE_CYCLES of them.
            always_comb begin
                acc_d = acc_q;
                cnt_d = cnt_q;
                if (pressed == acc_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    acc_d = ~acc_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Debounce state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                end
            end

            assign acc[gi] = acc_q;
        end
    endgenerate

    // Both keys held at once decodes as no key.
    logic key_up;
    logic key_dn;

    assign key_up = acc[0] & ~acc[1];
    assign key_dn = acc[1] & ~acc[0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            dir_q;     // 0 = up, 1 = down
    logic            dir_d;
    logic [FR_W-1:0] fr_q;
    logic [FR_W-1:0] fr_d;
    logic [FR_W-1:0] fr_inc;
    logic            held_match;
    logic            ev_up;
    logic            ev_dn;

    assign fr_inc     = fr_q + FR_W'(1);
    assign held_match = dir_q ? key_dn : key_up;

    // Press / auto-repeat sequencing; emits one-cycle events per request.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fr_d    = fr_q;
        ev_up   = 1'b0;
        ev_dn   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_up) begin
                    ev_up   = 1'b1;
                    dir_d   = 1'b0;
                    fr_d    = '0;
                    state_d = ST_FIRST;
                end else if (key_dn) begin
                    ev_dn   = 1'b1;
                    dir_d   = 1'b1;
                    fr_d    = '0;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (!held_match) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!held_match) begin
                    state_d = ST_IDLE;
                end else if (frame_en) begin
                    if (fr_inc == FR_DELAY) begin
                        ev_up   = ~dir_q;
                        ev_dn   = dir_q;
                        fr_d    = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        fr_d = fr_inc;
                    end
                end
            end
            ST_REPEAT: begin
                if (!held_match) begin
                    state_d = ST_IDLE;
                end else if (frame_en) begin
                    if (fr_inc == FR_RATE) begin
                        ev_up = ~dir_q;
                        ev_dn = dir_q;
                        fr_d  = '0;
                    end else begin
                        fr_d = fr_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            fr_q    <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fr_q    <= fr_d;
        end
    end

    logic inc_q;
    logic inc_d;
    logic dec_q;
    logic dec_d;

    // Request latch: frame_en consumes, a new event overrides consumption
    // and cancels the opposite direction.
    always_comb begin
        inc_d = inc_q;
        dec_d = dec_q;
        if (frame_en) begin
            inc_d = 1'b0;
            dec_d = 1'b0;
        end
        if (ev_up) begin
            inc_d = 1'b1;
            dec_d = 1'b0;
        end else if (ev_dn) begin
            dec_d = 1'b1;
            inc_d = 1'b0;
        end
    end

    // Request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
            dec_q <= dec_d;
        end
    end

    assign inc  = inc_q;
    assign dec  = dec_q;
    assign busy = (state_q != ST_IDLE);

endmodule
